// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types for the SRAM responder and its users.
// Holds the request/response structs, the access-size encoding and the responder state enum.
package dbus_sram_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'b000,
        MSIZE2 = 3'b001,
        MSIZE4 = 3'b010,
        MSIZE8 = 3'b011
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [63:0] data;
        logic [7:0]  strobe;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    // A 2^k-byte access must have its low k address bits clear; unknown sizes are held to 8-byte alignment.
    function automatic logic misaligned(input logic [2:0] addr_lo, input msize_t size);
        case (size)
            MSIZE1:  return 1'b0;
            MSIZE2:  return addr_lo[0] != 1'b0;
            MSIZE4:  return addr_lo[1:0] != 2'b00;
            default: return addr_lo != 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Request/response pair between the core's data port and the SRAM responder.
interface dbus_sram_responder_if;
    import dbus_sram_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder_sram_be.sv
// Synchronous single-port 64-bit SRAM with byte enables; read-first, data one cycle after en.
module dbus_sram_responder_sram_be #(
    parameter  int DEPTH = 4096,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [7:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[idx];
            for (int i = 0; i < 8; i++) begin
                if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus endpoint: serves one request at a time from a local SRAM after LATENCY cycles,
// answering with a single-cycle data_ok pulse and flagging protocol violations stickily.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter  logic [63:0] BASE    = 64'h8000_0000,
    parameter  int          DEPTH   = 4096,
    parameter  int          LATENCY = 2,
    localparam int          IDX_W   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    dbus_sram_responder_if.slave  dbus,
    output logic                  busy,
    output logic                  proto_err
);

    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        data_ok_q, data_ok_d;
    logic [63:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        proto_err_q, proto_err_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  strobe_q, strobe_d;

    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             sram_en;
    logic [7:0]       sram_we;
    logic [63:0]      rdata;
    logic [63:0]      resp_data;

    assign in_range  = (addr_q >= BASE) && (addr_q < LIMIT);
    assign idx       = IDX_W'((addr_q - BASE) >> 3);
    assign resp_data = in_range ? rdata : 64'h0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        proto_err_d = proto_err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strobe_d    = strobe_q;
        sram_en     = 1'b0;
        sram_we     = 8'h00;
        case (state_q)
            IDLE: begin
                if (dbus.dreq.valid) begin
                    addr_d   = dbus.dreq.addr;
                    wdata_d  = dbus.dreq.data;
                    strobe_d = dbus.dreq.strobe;
                    cnt_d    = 4'(LATENCY - 1);
                    state_d  = WAIT;
                    if (misaligned(dbus.dreq.addr[2:0], dbus.dreq.size)) proto_err_d = 1'b1;
                end
            end
            WAIT: begin
                // A withdrawn request wins over the counter expiring.
                if (!dbus.dreq.valid) begin
                    state_d = IDLE;
                end else begin
                    if (dbus.dreq.addr != addr_q || dbus.dreq.strobe != strobe_q) proto_err_d = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = RESP;
                        sram_en = in_range;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                // rdata still holds the pre-write word read in the last WAIT cycle.
                state_d = IDLE;
                data_d  = resp_data;
                sram_en = in_range && (strobe_q != 8'h00);
                sram_we = in_range ? strobe_q : 8'h00;
            end
            default: state_d = IDLE;
        endcase
        data_ok_d = (state_d == RESP);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            data_ok_q   <= 1'b0;
            data_q      <= 64'h0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_ok_q   <= data_ok_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        strobe_q <= strobe_d;
    end

    dbus_sram_responder_sram_be #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .idx   (idx),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign dbus.dresp.data_ok = data_ok_q;
    assign dbus.dresp.data    = (state_q == RESP) ? resp_data : data_q;
    assign busy               = busy_q;
    assign proto_err          = proto_err_q;

endmodule
